// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, FSM states, flag positions.
package alu_mc_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_EOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_UDIV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // MUL, UMULL and UDIV go through the one-bit-per-cycle engine.
  function automatic logic is_iter(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

endpackage

// File: rtl/alu_mc_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// Multiply: {hi,lo} starts as {0,A}; each step adds B to hi when lo[0]=1
// and shifts the pair right, leaving the 2*WIDTH product in {hi,lo}.
// Divide: hi is the partial remainder, lo shifts the dividend out and the
// quotient bits in.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt,
  output logic             last
);

  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic [CNTW-1:0]  cnt_q;
  logic             mode_q;
  logic [WIDTH:0]   sum, shifted, diff;

  // One multiply or divide iteration computed from the current registers.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (mode_q) begin
      if (shifted >= {1'b0, b_q}) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last = (cnt_q == CNTW'(WIDTH - 1));

  // Operand load on accept, then one iteration per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      lo_q   <= a;
      hi_q   <= '0;
      b_q    <= b;
      mode_q <= mode;
      cnt_q  <= '0;
    end else if (step) begin
      lo_q  <= lo_nxt;
      hi_q  <= hi_nxt;
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/EOR, iterative MUL/UMULL/UDIV.
// The FSM, the single-cycle datapath and the flag logic live here; the
// iterative engine is iter_muldiv.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       ALUFlags
);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic             divz_q;
  logic             accept, iter_op, last;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH-1:0] res_q, hi_q;
  logic [3:0]       flags_q;

  logic             sub;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic [3:0]       fin_flags;

  assign accept  = start && (state_q != ST_RUN);
  assign iter_op = is_iter(op);

  iter_muldiv #(.WIDTH(WIDTH), .CNTW(CNTW)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && iter_op),
    .step   (state_q == ST_RUN),
    .mode   (op == OP_UDIV),
    .a      (SrcA),
    .b      (SrcB),
    .lo_nxt (it_lo),
    .hi_nxt (it_hi),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only counts outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? (iter_op ? ST_RUN : ST_DONE) : ST_IDLE;
      ST_RUN:           if (last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Single-cycle datapath; SUB is A + ~B + 1 so C=1 means no borrow.
  always_comb begin
    sub       = (op == OP_SUB);
    b_eff     = sub ? ~SrcB : SrcB;
    sum       = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_V] = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  alu_res = SrcA & SrcB;
      OP_ORR:  alu_res = SrcA | SrcB;
      OP_EOR:  alu_res = SrcA ^ SrcB;
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  // Final iterative result, taken from the engine's last-step values.
  always_comb begin
    fin_res   = it_lo;
    fin_hi    = '0;
    fin_flags = '0;
    case (op_q)
      OP_UMULL: begin
        fin_hi            = it_hi;
        fin_flags[FLAG_N] = it_hi[WIDTH-1];
        fin_flags[FLAG_Z] = (it_hi == '0) && (it_lo == '0);
      end
      OP_UDIV: begin
        // A zero divisor yields all-ones quotient bits; report 0 instead.
        fin_res           = divz_q ? '0 : it_lo;
        fin_hi            = it_hi;
        fin_flags[FLAG_N] = fin_res[WIDTH-1];
        fin_flags[FLAG_Z] = (fin_res == '0);
      end
      default: begin
        fin_flags[FLAG_N] = it_lo[WIDTH-1];
        fin_flags[FLAG_Z] = (it_lo == '0);
      end
    endcase
  end

  // Capture the op and divide-by-zero condition at the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      divz_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      divz_q <= (SrcB == '0);
    end
  end

  // Result registers update only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else if (accept && !iter_op) begin
      res_q   <= alu_res;
      hi_q    <= '0;
      flags_q <= alu_flags;
    end else if ((state_q == ST_RUN) && last) begin
      res_q   <= fin_res;
      hi_q    <= fin_hi;
      flags_q <= fin_flags;
    end
  end

  assign Result   = res_q;
  assign ResultHi = hi_q;
  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32) with a scoreboard of expected results.
module tb_alu_mc;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [3:0]   f;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] SrcA, SrcB;
  logic         busy, done;
  logic [W-1:0] Result, ResultHi;
  logic [3:0]   ALUFlags;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .ALUFlags (ALUFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model using wide arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [W:0]  s;
    logic [63:0] p;
    e = '0;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.f[1] = s[W];
        e.f[0] = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b001: begin
        e.r = a - b;
        e.f[1] = (a >= b);
        e.f[0] = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b010: e.r = a & b;
      3'b011: e.r = a | b;
      3'b100: e.r = a ^ b;
      3'b101: e.r = p[W-1:0];
      3'b110: begin
        e.r = p[W-1:0];
        e.h = p[63:32];
      end
      default: begin
        if (b == 0) begin
          e.r = '0;
          e.h = a;
        end else begin
          e.r = a / b;
          e.h = a % b;
        end
      end
    endcase
    if (o == 3'b110) begin
      e.f[3] = e.h[W-1];
      e.f[2] = (p == 64'd0);
    end else begin
      e.f[3] = e.r[W-1];
      e.f[2] = (e.r == '0);
    end
    return e;
  endfunction

  // Scoreboard: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("Result", {32'd0, Result}, {32'd0, e.r});
        chk("ResultHi", {32'd0, ResultHi}, {32'd0, e.h});
        chk("ALUFlags", {60'd0, ALUFlags}, {60'd0, e.f});
      end
    end
  end

  // Waits (from a negedge) until done is seen; returns cycles waited.
  task automatic wait_done(output int n, output int busy_n, output logic stable);
    logic [W-1:0] hold;
    hold   = Result;
    n      = 0;
    busy_n = 0;
    stable = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_n++;
      if (Result !== hold) stable = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one op, scramble inputs after accept, check latency and busy span.
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int lat);
    int   n, bn;
    logic st;
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    wait_done(n, bn, st);
    chk("latency", 64'(n + 1), 64'(lat));
    chk("busy_cycles", 64'(bn), 64'(lat - 1));
    chk("hold_while_busy", {63'd0, st}, 64'd1);
  endtask

  initial begin
    int   n, bn, d0;
    logic st;
    reset = 1'b1; start = 1'b0; op = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_Result", {32'd0, Result}, 64'd0);
    chk("rst_ResultHi", {32'd0, ResultHi}, 64'd0);
    chk("rst_ALUFlags", {60'd0, ALUFlags}, 64'd0);
    reset = 1'b0;

    // 1: signed overflow on ADD
    run(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1);

    // 2: SUB then back-to-back ORR with start held through DONE
    @(negedge clk);
    op = 3'b001; SrcA = 32'd5; SrcB = 32'd5; start = 1'b1;
    sb.push_back(model(3'b001, 32'd5, 32'd5));
    @(negedge clk);
    chk("sub_done", {63'd0, done}, 64'd1);
    op = 3'b011; SrcA = 32'hF0; SrcB = 32'h0F;
    sb.push_back(model(3'b011, 32'hF0, 32'h0F));
    @(negedge clk);
    chk("orr_b2b_done", {63'd0, done}, 64'd1);
    start = 1'b0;
    @(negedge clk);
    chk("done_drops", {63'd0, done}, 64'd0);

    // 3, 4: iterative ops
    run(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run(3'b111, 32'd100, 32'd7, 33);
    run(3'b111, 32'd9, 32'd0, 33);
    run(3'b100, 32'hA5A5_0000, 32'hFFFF_00FF, 1);

    // 5: start while busy is ignored
    @(negedge clk);
    d0 = done_cnt;
    op = 3'b101; SrcA = 32'd3; SrcB = 32'd4; start = 1'b1;
    sb.push_back(model(3'b101, 32'd3, 32'd4));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    op = 3'b000; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bn, st);
    chk("mul_ignore_latency", 64'(n + 10), 64'd33);
    repeat (3) @(negedge clk);
    chk("one_done_pulse", 64'(done_cnt - d0), 64'd1);
    chk("sb_empty_after_mul", 64'(sb.size()), 64'd0);

    // 6: reset during RUN aborts without a done pulse
    @(negedge clk);
    op = 3'b111; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    sb.push_back(model(3'b111, 32'd1000, 32'd3));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_Result", {32'd0, Result}, 64'd0);
    chk("abort_ResultHi", {32'd0, ResultHi}, 64'd0);
    chk("abort_ALUFlags", {60'd0, ALUFlags}, 64'd0);
    sb.delete();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);

    // A few random operations through the model.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      o = 3'($urandom);
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run(o, a, b, (o >= 3'b101) ? 33 : 1);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
